// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, index/word types and index qualifiers for the register file
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = $clog2(NREGS);

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_word_t;

  function automatic logic idx_valid(reg_idx_t idx);
    return int'(idx) < NREGS;
  endfunction

  // A "live" register holds state: in range and not the hardwired zero register.
  function automatic logic reg_live(reg_idx_t idx, logic r0_zero);
    return idx_valid(idx) && !(r0_zero && (idx == '0));
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending bits with two registered busy lookups
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     en,
  input  logic     wr_en,
  input  reg_idx_t wr_addr,
  input  logic     pend_set,
  input  reg_idx_t pend_addr,
  input  reg_idx_t rd_addr_a,
  input  reg_idx_t rd_addr_b,
  output logic     busy_a,
  output logic     busy_b
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;
  logic             wr_ok;
  logic             pend_ok;
  logic             busy_next_a;
  logic             busy_next_b;

  // Set is applied after clear so a new load issued alongside a writeback wins.
  always_comb begin
    wr_ok        = wr_en && reg_live(wr_addr, R0_ZERO);
    pend_ok      = pend_set && reg_live(pend_addr, R0_ZERO);
    pending_next = pending;
    if (wr_ok)   pending_next[wr_addr]   = 1'b0;
    if (pend_ok) pending_next[pend_addr] = 1'b1;
    busy_next_a  = reg_live(rd_addr_a, R0_ZERO) && pending_next[rd_addr_a];
    busy_next_b  = reg_live(rd_addr_b, R0_ZERO) && pending_next[rd_addr_b];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      busy_a  <= 1'b0;
      busy_b  <= 1'b0;
    end else if (en) begin
      pending <= pending_next;
      busy_a  <= busy_next_a;
      busy_b  <= busy_next_b;
    end
  end

endmodule

// File: rtl/reg_file_rd.sv
// rtl/reg_file_rd.sv - 1W/2R register file with write forwarding and load scoreboard
module reg_file_rd
  import regfile_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      wr_en,
  input  reg_idx_t  wr_addr,
  input  reg_word_t wr_data,
  input  logic      pend_set,
  input  reg_idx_t  pend_addr,
  input  reg_idx_t  rd_addr_a,
  input  reg_idx_t  rd_addr_b,
  output reg_word_t rd_data_a,
  output reg_word_t rd_data_b,
  output logic      rd_busy_a,
  output logic      rd_busy_b
);

  reg_word_t regs [NREGS];
  reg_word_t rd_next_a;
  reg_word_t rd_next_b;
  logic      wr_ok;

  // Forward the incoming writeback so readers see the new value, not the old one.
  always_comb begin
    wr_ok     = wr_en && reg_live(wr_addr, R0_ZERO);
    rd_next_a = '0;
    rd_next_b = '0;
    if (reg_live(rd_addr_a, R0_ZERO))
      rd_next_a = (wr_ok && (wr_addr == rd_addr_a)) ? wr_data : regs[rd_addr_a];
    if (reg_live(rd_addr_b, R0_ZERO))
      rd_next_b = (wr_ok && (wr_addr == rd_addr_b)) ? wr_data : regs[rd_addr_b];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else if (en) begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      rd_data_a <= rd_next_a;
      rd_data_b <= rd_next_b;
    end
  end

  reg_scoreboard #(.R0_ZERO(R0_ZERO)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .busy_a    (rd_busy_a),
    .busy_b    (rd_busy_b)
  );

endmodule

// File: tb/tb_reg_file_rd.sv
// tb/tb_reg_file_rd.sv - randomized self-checking bench for reg_file_rd against a state model
module tb_reg_file_rd;

  logic        clk = 1'b0;
  logic        reset, en, wr_en, pend_set;
  logic [2:0]  wr_addr, pend_addr, rd_addr_a, rd_addr_b;
  logic [15:0] wr_data;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_regs [8];
  logic        m_pend [8];
  logic [15:0] m_rda, m_rdb;
  logic        m_bza, m_bzb;

  always #5 clk = ~clk;

  reg_file_rd dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_busy_a (rd_busy_a),
    .rd_busy_b (rd_busy_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: architectural state after the edge; each read port reports the
  // post-edge value and pending status of the register it addressed.
  task automatic cycle();
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_rda = '0; m_rdb = '0; m_bza = 1'b0; m_bzb = 1'b0;
    end else if (en) begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
      m_rda = m_regs[rd_addr_a];
      m_rdb = m_regs[rd_addr_b];
      m_bza = m_pend[rd_addr_a];
      m_bzb = m_pend[rd_addr_b];
    end
    @(posedge clk);
    #1;
    check("rd_data_a", rd_data_a, m_rda);
    check("rd_data_b", rd_data_b, m_rdb);
    check("rd_busy_a", {15'b0, rd_busy_a}, {15'b0, m_bza});
    check("rd_busy_b", {15'b0, rd_busy_b}, {15'b0, m_bzb});
  endtask

  task automatic drive(input logic e, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic ps, input logic [2:0] pa, input logic [2:0] ra, input logic [2:0] rb);
    en = e; wr_en = we; wr_addr = wa; wr_data = wd;
    pend_set = ps; pend_addr = pa; rd_addr_a = ra; rd_addr_b = rb;
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("reset_data_a", rd_data_a, 16'h0000);
    reset = 1'b0;

    // 1: preload, pend, then reset drops everything
    for (int i = 1; i < 8; i++) drive(1, 1, 3'(i), 16'hA000 + 16'(i), 1, 3'(8 - i), 0, 0);
    reset = 1'b1;
    drive(1, 1, 4, 16'h7777, 1, 4, 4, 5);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
      check("post_reset_a", rd_data_a, 16'h0000);
      check("post_reset_busy_b", {15'b0, rd_busy_b}, 16'h0000);
    end

    // 2: write then read
    drive(1, 1, 3, 16'hBEEF, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 3, 0);
    check("t2_read_r3", rd_data_a, 16'hBEEF);

    // 3: same-cycle write forwarding
    drive(1, 1, 5, 16'h1234, 0, 0, 0, 5);
    check("t3_fwd_r5", rd_data_b, 16'h1234);

    // 4: scoreboard set / clear / set-wins
    drive(1, 0, 0, 0, 1, 2, 2, 0);
    check("t4_busy_set", {15'b0, rd_busy_a}, 16'h0001);
    drive(1, 0, 0, 0, 0, 0, 2, 2);
    check("t4_busy_held", {15'b0, rd_busy_b}, 16'h0001);
    drive(1, 1, 2, 16'h00AA, 0, 0, 2, 0);
    check("t4_wb_data", rd_data_a, 16'h00AA);
    check("t4_wb_busy", {15'b0, rd_busy_a}, 16'h0000);
    drive(1, 1, 2, 16'h00BB, 1, 2, 2, 2);
    check("t4_setwins_busy", {15'b0, rd_busy_a}, 16'h0001);

    // 5: hardwired zero register
    drive(1, 1, 0, 16'hFFFF, 1, 0, 0, 0);
    check("t5_r0_fwd", rd_data_a, 16'h0000);
    check("t5_r0_busy", {15'b0, rd_busy_b}, 16'h0000);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("t5_r0_read", rd_data_b, 16'h0000);

    // 6: clock enable freezes state and outputs
    drive(1, 1, 1, 16'h1111, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 16'h5555, 1, 1, 1, 3);
      check("t6_frozen_a", rd_data_a, 16'h1111);
      check("t6_frozen_busy", {15'b0, rd_busy_a}, 16'h0000);
    end
    drive(1, 0, 0, 0, 0, 0, 1, 3);
    check("t6_resume_r1", rd_data_a, 16'h1111);
    check("t6_resume_busy", {15'b0, rd_busy_a}, 16'h0000);
    check("t6_resume_r3", rd_data_b, 16'hBEEF);

    // Randomized traffic, small address space to provoke collisions
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 7) != 0), 1'($urandom), 3'($urandom), 16'($urandom),
            ($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom), 3'($urandom));
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
